sdram_row_buffer: RTL and testbench

Row buffer (sense-amp latch) directly downstream of one bank's memory core rows. On Activate it pulses the core read enable, captures the full 64-word row in one cycle, and serves column read/write bursts from that local copy. On Precharge it writes the row back to the core if the row was modified. It presents a column-level interface to the bank controller and a flat full-row interface to the core.

---
 rtl/sdram_row_buffer.sv | 170 +++++++++++++++++
 tb/tb_sdram_row_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_row_buffer.sv
// Row buffer for one bank: loads a full core row on Activate, serves column
// bursts from the local copy and writes it back on Precharge when modified.
module sdram_row_buffer #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int COL_ELEM_COUNT = 64,
    parameter int COL_ADDR_WIDTH = 6,
    parameter int BURST_LEN      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     Activate,
    input  logic                                     Read,
    input  logic                                     Write,
    input  logic                                     Precharge,
    input  logic [COL_ADDR_WIDTH-1:0]                ColAddr,
    input  logic [DATA_BIT_WIDTH-1:0]                DataIn,
    output logic [DATA_BIT_WIDTH-1:0]                DataOut,
    output logic                                     DataValid,
    output logic                                     CmdReady,
    output logic                                     RowOpen,
    output logic                                     CoreRE,
    output logic                                     CoreWE,
    input  logic [COL_ELEM_COUNT*DATA_BIT_WIDTH-1:0] RowDataIn,
    output logic [COL_ELEM_COUNT*DATA_BIT_WIDTH-1:0] RowDataOut,
    output logic [2:0]                               state_dbg_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_OPEN = 3'd2,
        S_RD   = 3'd3,
        S_WR   = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t                    state_q;
    logic [COL_ADDR_WIDTH-1:0] ptr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      dirty_q;
    logic [DATA_BIT_WIDTH-1:0] buf_q [COL_ELEM_COUNT];

    logic                      wr_en_d;
    logic [COL_ADDR_WIDTH-1:0] wr_addr_d;

    assign state_dbg_o = state_q;

    for (genvar g = 0; g < COL_ELEM_COUNT; g++) begin : g_row_out
        assign RowDataOut[g*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = buf_q[g];
    end

    // Handshake: a command is a one-cycle pulse taken only on a cycle with
    // CmdReady=1; when CmdReady=0 it is dropped, never queued.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = ColAddr;
        if (state_q == S_OPEN && !Read && Write) begin
            wr_en_d = 1'b1;
        end else if (state_q == S_WR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_ACT) begin
                for (int i = 0; i < COL_ELEM_COUNT; i++) begin
                    buf_q[i] <= RowDataIn[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
                end
            end else if (wr_en_d) begin
                buf_q[wr_addr_d] <= DataIn;
            end
        end
    end

    // cnt_q counts words already transferred in the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            DataOut   <= '0;
            DataValid <= 1'b0;
            CmdReady  <= 1'b1;
            RowOpen   <= 1'b0;
            CoreRE    <= 1'b0;
            CoreWE    <= 1'b0;
            dirty_q   <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            CoreRE <= 1'b0;
            CoreWE <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Activate) begin
                        state_q  <= S_ACT;
                        CoreRE   <= 1'b1;
                        CmdReady <= 1'b0;
                    end
                end
                S_ACT: begin
                    state_q  <= S_OPEN;
                    dirty_q  <= 1'b0;
                    CmdReady <= 1'b1;
                    RowOpen  <= 1'b1;
                end
                S_OPEN: begin
                    if (Read) begin
                        state_q   <= S_RD;
                        DataOut   <= buf_q[ColAddr];
                        DataValid <= 1'b1;
                        ptr_q     <= ColAddr + COL_ADDR_WIDTH'(1);
                        cnt_q     <= CNT_W'(1);
                        CmdReady  <= 1'b0;
                    end else if (Write) begin
                        dirty_q <= 1'b1;
                        if (BURST_LEN > 1) begin
                            state_q  <= S_WR;
                            ptr_q    <= ColAddr + COL_ADDR_WIDTH'(1);
                            cnt_q    <= CNT_W'(1);
                            CmdReady <= 1'b0;
                        end
                    end else if (Precharge) begin
                        RowOpen <= 1'b0;
                        if (dirty_q) begin
                            state_q  <= S_WB;
                            CoreWE   <= 1'b1;
                            CmdReady <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == CNT_W'(BURST_LEN)) begin
                        state_q   <= S_OPEN;
                        DataValid <= 1'b0;
                        CmdReady  <= 1'b1;
                    end else begin
                        DataOut <= buf_q[ptr_q];
                        ptr_q   <= ptr_q + COL_ADDR_WIDTH'(1);
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR: begin
                    ptr_q <= ptr_q + COL_ADDR_WIDTH'(1);
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_q  <= S_OPEN;
                        CmdReady <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q  <= S_IDLE;
                    dirty_q  <= 1'b0;
                    CmdReady <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    DataValid <= 1'b0;
                    CmdReady  <= 1'b1;
                    RowOpen   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_row_buffer.sv
// Bench for sdram_row_buffer: vector table of read bursts, hand-written corner
// sequences, then random traffic against an array model of buffer and core.
module tb_sdram_row_buffer;

    localparam int DW = 32;
    localparam int NC = 64;
    localparam int AW = 6;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            Activate, Read, Write, Precharge;
    logic [AW-1:0]   ColAddr;
    logic [DW-1:0]   DataIn;
    logic [DW-1:0]   DataOut;
    logic            DataValid, CmdReady, RowOpen, CoreRE, CoreWE;
    logic [NC*DW-1:0] row_in;
    logic [NC*DW-1:0] row_out;
    logic [2:0]      state_dbg;

    sdram_row_buffer #(
        .DATA_BIT_WIDTH(DW), .COL_ELEM_COUNT(NC), .COL_ADDR_WIDTH(AW), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst), .Activate(Activate), .Read(Read), .Write(Write),
        .Precharge(Precharge), .ColAddr(ColAddr), .DataIn(DataIn), .DataOut(DataOut),
        .DataValid(DataValid), .CmdReady(CmdReady), .RowOpen(RowOpen), .CoreRE(CoreRE),
        .CoreWE(CoreWE), .RowDataIn(row_in), .RowDataOut(row_out), .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            col;
        logic [DW-1:0] e0, e1, e2, e3;
    } rd_vec_t;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] core_mem [NC];
    logic [DW-1:0] m_buf [NC];
    bit            m_dirty, m_open;
    logic [DW-1:0] rd_words [BL];
    logic [DW-1:0] wr_words [BL];
    logic [DW-1:0] wb_words [NC];
    bit            wb_seen;
    rd_vec_t       rd_tab [5];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push_core();
        for (int i = 0; i < NC; i++) row_in[i*DW +: DW] = core_mem[i];
    endtask

    task automatic clear_inputs();
        Activate = 1'b0; Read = 1'b0; Write = 1'b0; Precharge = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk1("re_we_exclusive", CoreRE & CoreWE, 1'b0);
        if (CoreWE) begin
            wb_seen = 1'b1;
            for (int i = 0; i < NC; i++) wb_words[i] = row_out[i*DW +: DW];
        end
    endtask

    task automatic do_activate();
        chk1("act_pre_ready", CmdReady, 1'b1);
        Activate = 1'b1;
        cyc();
        Activate = 1'b0;
        chk1("act_core_re", CoreRE, 1'b1);
        chk1("act_busy", CmdReady, 1'b0);
        chk1("act_not_open", RowOpen, 1'b0);
        cyc();
        chk1("act_re_pulse_end", CoreRE, 1'b0);
        chk1("act_open", RowOpen, 1'b1);
        chk1("act_open_ready", CmdReady, 1'b1);
        for (int i = 0; i < NC; i++) m_buf[i] = core_mem[i];
        m_dirty = 1'b0;
        m_open  = 1'b1;
    endtask

    task automatic read_burst(input int col, input bit with_wr, input bit with_act,
                              input bit with_pre, input bit poke);
        Read = 1'b1; ColAddr = AW'(col);
        Write = with_wr; DataIn = $urandom; Activate = with_act; Precharge = with_pre;
        cyc();
        clear_inputs();
        for (int k = 0; k < BL; k++) begin
            chk1("rd_valid", DataValid, 1'b1);
            chk1("rd_busy", CmdReady, 1'b0);
            chk1("rd_open", RowOpen, 1'b1);
            chk("rd_data", DataOut, m_buf[(col + k) % NC]);
            rd_words[k] = DataOut;
            if (poke && k == 0) begin
                Read = 1'b1; ColAddr = AW'(col + 17);
            end
            cyc();
            Read = 1'b0;
        end
        chk1("rd_done_valid", DataValid, 1'b0);
        chk1("rd_done_ready", CmdReady, 1'b1);
        chk1("rd_done_open", RowOpen, 1'b1);
    endtask

    task automatic write_burst(input int col);
        Write = 1'b1; ColAddr = AW'(col); DataIn = wr_words[0];
        cyc();
        Write = 1'b0;
        for (int k = 1; k < BL; k++) begin
            chk1("wr_busy", CmdReady, 1'b0);
            chk1("wr_open", RowOpen, 1'b1);
            chk1("wr_no_valid", DataValid, 1'b0);
            DataIn = wr_words[k];
            cyc();
        end
        chk1("wr_done_ready", CmdReady, 1'b1);
        chk1("wr_done_open", RowOpen, 1'b1);
        for (int k = 0; k < BL; k++) m_buf[(col + k) % NC] = wr_words[k];
        m_dirty = 1'b1;
    endtask

    task automatic do_precharge();
        int errs;
        wb_seen = 1'b0;
        Precharge = 1'b1;
        cyc();
        Precharge = 1'b0;
        chk1("pre_closed", RowOpen, 1'b0);
        if (m_dirty) begin
            chk1("pre_core_we", CoreWE, 1'b1);
            chk1("pre_wb_busy", CmdReady, 1'b0);
            errs = 0;
            for (int i = 0; i < NC; i++) if (row_out[i*DW +: DW] !== m_buf[i]) errs++;
            chk("wb_row_words_wrong", errs, 0);
            cyc();
            chk1("wb_we_pulse_end", CoreWE, 1'b0);
            chk1("wb_idle_ready", CmdReady, 1'b1);
            chk1("wb_idle_closed", RowOpen, 1'b0);
            for (int i = 0; i < NC; i++) core_mem[i] = m_buf[i];
            push_core();
        end else begin
            chk1("pre_clean_no_we", CoreWE, 1'b0);
            chk1("pre_clean_idle", CmdReady, 1'b1);
            cyc();
            chk1("pre_clean_no_wb", wb_seen, 1'b0);
        end
        m_open  = 1'b0;
        m_dirty = 1'b0;
    endtask

    task automatic idle_noise();
        Read = 1'($urandom_range(0, 1)); Write = 1'b1; Precharge = 1'b1;
        ColAddr = AW'($urandom); DataIn = $urandom;
        cyc();
        clear_inputs();
        chk1("idle_ignore_open", RowOpen, 1'b0);
        chk1("idle_ignore_re", CoreRE, 1'b0);
        chk1("idle_ignore_we", CoreWE, 1'b0);
        chk1("idle_ignore_ready", CmdReady, 1'b1);
    endtask

    initial begin
        int errs;
        int op;
        rst = 1'b1;
        clear_inputs();
        ColAddr = '0;
        DataIn = '0;
        m_open = 1'b0;
        m_dirty = 1'b0;
        wb_seen = 1'b0;
        for (int i = 0; i < NC; i++) core_mem[i] = 32'hA000_0000 + DW'(i);
        push_core();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataout", DataOut, '0);
        chk1("rst_valid", DataValid, 1'b0);
        chk1("rst_core_re", CoreRE, 1'b0);
        chk1("rst_core_we", CoreWE, 1'b0);
        chk1("rst_row_open", RowOpen, 1'b0);
        chk1("rst_ready", CmdReady, 1'b1);
        rst = 1'b0;
        idle_noise();

        rd_tab[0] = '{5,  32'hA000_0005, 32'hA000_0006, 32'hA000_0007, 32'hA000_0008};
        rd_tab[1] = '{62, 32'hA000_003E, 32'hA000_003F, 32'hA000_0000, 32'hA000_0001};
        rd_tab[2] = '{0,  32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        rd_tab[3] = '{63, 32'hA000_003F, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
        rd_tab[4] = '{33, 32'hA000_0021, 32'hA000_0022, 32'hA000_0023, 32'hA000_0024};

        do_activate();
        for (int t = 0; t < 5; t++) begin
            read_burst(rd_tab[t].col, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("tab_word0", rd_words[0], rd_tab[t].e0);
            chk("tab_word1", rd_words[1], rd_tab[t].e1);
            chk("tab_word2", rd_words[2], rd_tab[t].e2);
            chk("tab_word3", rd_words[3], rd_tab[t].e3);
        end

        // write, read back, dirty writeback
        wr_words[0] = 32'h11; wr_words[1] = 32'h22; wr_words[2] = 32'h33; wr_words[3] = 32'h44;
        write_burst(10);
        read_burst(10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr_rd_word0", rd_words[0], 32'h11);
        chk("wr_rd_word1", rd_words[1], 32'h22);
        chk("wr_rd_word2", rd_words[2], 32'h33);
        chk("wr_rd_word3", rd_words[3], 32'h44);
        do_precharge();
        chk1("wb_seen", wb_seen, 1'b1);
        errs = 0;
        for (int i = 0; i < NC; i++) begin
            if (i >= 10 && i <= 13) begin
                if (wb_words[i] !== DW'(32'h11 * (i - 9))) errs++;
            end else if (wb_words[i] !== 32'hA000_0000 + DW'(i)) begin
                errs++;
            end
        end
        chk("wb_row_fixed_words_wrong", errs, 0);

        // clean row: reload shows written-back data, no CoreWE on close
        do_activate();
        read_burst(10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reload_word0", rd_words[0], 32'h11);
        chk("reload_word3", rd_words[3], 32'h44);
        do_precharge();

        // priority and ignored commands
        do_activate();
        read_burst(20, 1'b1, 1'b0, 1'b0, 1'b0);
        read_burst(20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rdwr_unchanged0", rd_words[0], 32'hA000_0014);
        chk("rdwr_unchanged3", rd_words[3], 32'hA000_0017);
        Activate = 1'b1;
        cyc();
        Activate = 1'b0;
        chk1("open_act_no_re", CoreRE, 1'b0);
        chk1("open_act_open", RowOpen, 1'b1);
        chk1("open_act_ready", CmdReady, 1'b1);
        read_burst(30, 1'b0, 1'b1, 1'b1, 1'b1);
        chk1("rd_pre_dropped_open", RowOpen, 1'b1);
        do_precharge();

        // reset in the middle of a write burst
        do_activate();
        Write = 1'b1; ColAddr = AW'(40); DataIn = 32'hCAFE_0001;
        cyc();
        Write = 1'b0; DataIn = 32'hCAFE_0002; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk1("mid_rst_valid", DataValid, 1'b0);
        chk1("mid_rst_open", RowOpen, 1'b0);
        chk1("mid_rst_ready", CmdReady, 1'b1);
        chk1("mid_rst_we", CoreWE, 1'b0);
        chk("mid_rst_dataout", DataOut, '0);
        m_open = 1'b0;
        m_dirty = 1'b0;
        wb_seen = 1'b0;
        Precharge = 1'b1;
        cyc();
        Precharge = 1'b0;
        cyc();
        chk1("mid_rst_pre_no_wb", wb_seen, 1'b0);
        chk1("mid_rst_pre_closed", RowOpen, 1'b0);
        do_activate();
        read_burst(40, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_reload", rd_words[0], 32'hA000_0028);
        do_precharge();

        // random traffic against the model
        for (int it = 0; it < 300; it++) begin
            if (!m_open) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle_noise();
                end else begin
                    if ($urandom_range(0, 1) == 1) begin
                        for (int i = 0; i < NC; i++) core_mem[i] = $urandom;
                        push_core();
                    end
                    do_activate();
                end
            end else begin
                op = $urandom_range(0, 9);
                if (op <= 3) begin
                    read_burst($urandom_range(0, NC - 1), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)));
                end else if (op <= 7) begin
                    for (int k = 0; k < BL; k++) wr_words[k] = $urandom;
                    write_burst($urandom_range(0, NC - 1));
                end else if (op == 8) begin
                    do_precharge();
                end else begin
                    Activate = 1'b1;
                    cyc();
                    Activate = 1'b0;
                    chk1("rand_open_act_no_re", CoreRE, 1'b0);
                    chk1("rand_open_act_open", RowOpen, 1'b1);
                end
            end
        end
        if (m_open) do_precharge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
